// File: rtl/gray_code_generator.sv
// ============================================================================
// gray_code_generator
//
// Purpose:
//   Sequential source of Gray-code words. A binary up/down step counter
//   advances on each tick. Its registered value is exported as `bin`. The same
//   value is exported re-encoded as Gray code (bin ^ bin>>1) on `gray`. Both
//   registers update on the same edge, so they are always consistent.
//
//   Tick source (selected by the STEP_BTN_EN macro):
//     - STEP_BTN_EN undefined (default): a free-running prescaler. It counts
//       0..DIV-1 while en=1 and produces one tick every DIV enabled cycles.
//     - STEP_BTN_EN defined: the prescaler is removed. The raw push button
//       `btn_step` goes through a 2-FF synchronizer and a rising-edge
//       detector. Each detected edge with en=1 is one tick. The latency from
//       a button rise to the gray update is 3 clk.
//
// Parameters:
//   WIDTH  counter / Gray word width in bits
//   DIV    clk cycles per automatic step (>=2); unused with STEP_BTN_EN
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous reset, active-low
//   en        in   1      1 = counting enabled; 0 = hold prescaler/bin/gray
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous load of load_bin (priority over tick)
//   load_bin  in   WIDTH  binary value to load
//   btn_step  in   1      raw push button (only with STEP_BTN_EN)
//   gray      out  WIDTH  registered Gray code of bin
//   bin       out  WIDTH  registered binary count
//   step      out  1      1-cycle pulse: gray changed due to a step
//   wrap      out  1      1-cycle pulse: step crossed max->0 or 0->max
// ============================================================================
module gray_code_generator #(
    parameter int WIDTH = 4,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
`ifdef STEP_BTN_EN
    input  logic             btn_step,
`endif
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             step,
    output logic             wrap
);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic tick;

`ifdef STEP_BTN_EN
    // Button path. sync[1] is the metastability-safe copy of the button.
    // btn_prev holds the previous value of sync[1] for the rising-edge detector.
    logic [1:0] sync;
    logic       btn_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            btn_prev <= 1'b0;
        end else begin
            sync     <= {sync[0], btn_step};
            btn_prev <= sync[1];
        end
    end

    assign tick = en && sync[1] && !btn_prev;
`else
    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] presc;

    // A load restarts the step period, so the next step comes a full
    // DIV enabled cycles after the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (load) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick = en && (presc == LAST);
`endif

    // Next-count candidates. They are used only on a tick edge, so `up` may
    // change freely in every other cycle.
    logic [WIDTH-1:0] next_bin;
    logic             next_wrap;

    assign next_bin  = up ? bin + 1'b1 : bin - 1'b1;
    assign next_wrap = up ? (bin == '1) : (bin == '0);

    // NOTE: sequential state uses non-blocking assignments. Then every register
    // in this block samples the pre-edge values of the others, regardless of
    // statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            bin  <= load_bin;
            gray <= to_gray(load_bin);
            step <= 1'b0;
            wrap <= 1'b0;
        end else if (tick) begin
            bin  <= next_bin;
            gray <= to_gray(next_bin);
            step <= 1'b1;
            wrap <= next_wrap;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_code_generator.sv
// ============================================================================
// tb_gray_code_generator
//
// Purpose:
//   Self-checking bench for gray_code_generator with WIDTH=4 and DIV=4.
//
//   The reference model counts enabled cycles since the last reset, load or
//   step. It steps the integer count modulo 16 every fourth such cycle. The
//   expected Gray word is derived bit by bit from the count.
//
//   A single compare process checks bin, gray, step and wrap shortly after
//   every rising edge. On every step it also checks that exactly one Gray bit
//   changed.
//
//   Directed sequences pin the model to hand-computed literal values. A
//   randomized phase then exercises en, up, load and reset.
// ============================================================================
module tb_gray_code_generator;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             up = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_bin = '0;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             step;
    logic             wrap;
`ifdef STEP_BTN_EN
    logic             btn_step = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    gray_code_generator #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
`ifdef STEP_BTN_EN
        .btn_step (btn_step),
`endif
        .gray     (gray),
        .bin      (bin),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Gray word from its definition: each bit is the XOR of the binary bit
    // and the next-higher binary bit (the top bit is copied).
    function automatic logic [WIDTH-1:0] gray_of(input int b);
        logic [WIDTH-1:0] g;
        for (int i = 0; i < WIDTH; i++)
            g[i] = ((b >> i) & 1) ^ ((i < WIDTH - 1) ? ((b >> (i + 1)) & 1) : 0);
        return g;
    endfunction

    // ---------------- reference model + compare process ----------------
    int m_bin  = 0;
    int m_run  = 0;   // enabled cycles since last reset/load/step
    bit m_step = 0;
    bit m_wrap = 0;

    initial begin
        logic [WIDTH-1:0] prev_g;
        forever begin
            @(posedge clk);
            prev_g = gray_of(m_bin);
            if (!rst_n) begin
                m_bin = 0; m_run = 0; m_step = 0; m_wrap = 0;
            end else if (load) begin
                m_bin = int'(load_bin); m_run = 0; m_step = 0; m_wrap = 0;
            end else if (en) begin
                m_run++;
                if (m_run == DIV) begin
                    m_run  = 0;
                    m_wrap = up ? (m_bin == MAXV) : (m_bin == 0);
                    m_bin  = (m_bin + (up ? 1 : -1)) & MAXV;
                    m_step = 1;
                end else begin
                    m_step = 0; m_wrap = 0;
                end
            end else begin
                m_step = 0; m_wrap = 0;
            end
            #1;
            check("cyc_bin",  bin,  m_bin);
            check("cyc_gray", gray, gray_of(m_bin));
            check("cyc_step", step, m_step);
            check("cyc_wrap", wrap, m_wrap);
            if (m_step) check("cyc_one_bit", $countones(gray ^ prev_g), 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits for the next step pulse within a cycle budget. Returns at
    // posedge+2 and reports how many edges it took.
    task automatic wait_step(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #2;
            cycles++;
        end while (!step && cycles < budget);
        if (!step) check("step_timeout", 0, 1);
    endtask

    logic [WIDTH-1:0] up_seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                     4'b0111, 4'b0101, 4'b0100, 4'b1100};

    initial begin
        int c;

        // Counting up from reset, with literal Gray sequence.
        en = 1'b1; up = 1'b1;
        do_reset();
        check("rst_gray", gray, 0);
        check("rst_bin",  bin,  0);
        for (int k = 0; k < 8; k++) begin
            wait_step(2 * DIV, c);
            check("up_period", c, DIV);
            check("up_gray", gray, up_seq[k]);
        end
        for (int k = 9; k <= 15; k++) wait_step(2 * DIV, c);
        check("max_bin",  bin,  15);
        check("max_gray", gray, 4'b1000);
        wait_step(2 * DIV, c);
        check("wrap_bin",  bin,  0);
        check("wrap_gray", gray, 0);
        check("wrap_pulse", wrap, 1);
        @(posedge clk); #2;
        check("wrap_end",  wrap, 0);
        check("step_end",  step, 0);

        // Asynchronous reset mid-count at bin=5.
        do_reset();
        for (int k = 0; k < 5; k++) wait_step(2 * DIV, c);
        check("pre_rst_bin", bin, 5);
        rst_n = 1'b0;
        #1;
        check("async_gray", gray, 0);
        check("async_bin",  bin,  0);
        check("async_step", step, 0);
        check("async_wrap", wrap, 0);

        // Counting down from reset.
        up = 1'b0;
        do_reset();
        wait_step(2 * DIV, c);
        check("dn_bin0",  bin,  15);
        check("dn_gray0", gray, 4'b1000);
        check("dn_wrap0", wrap, 1);
        wait_step(2 * DIV, c);
        check("dn_bin1",  bin,  14);
        check("dn_gray1", gray, 4'b1001);
        check("dn_wrap1", wrap, 0);

        // Load in the same cycle as a tick.
        up = 1'b1;
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        load = 1'b1; load_bin = 4'b1010;
        @(posedge clk); #2;
        check("ld_bin",  bin,  4'b1010);
        check("ld_gray", gray, 4'b1111);
        check("ld_step", step, 0);
        @(negedge clk);
        load = 1'b0;
        wait_step(2 * DIV, c);
        check("ld_period", c, DIV);
        check("ld_bin1",  bin,  4'b1011);
        check("ld_gray1", gray, 4'b1110);

        // Enable low for 10 clk at bin=3.
        do_reset();
        for (int k = 0; k < 3; k++) wait_step(2 * DIV, c);
        repeat (2) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("hold_bin",  bin,  3);
        check("hold_gray", gray, 4'b0010);
        check("hold_step", step, 0);
        @(negedge clk);
        en = 1'b1;
        wait_step(2 * DIV, c);
        check("resume_cycles", c, 2);
        check("resume_bin", bin, 4);

        // Randomized phase; the compare process checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            load     = ($urandom_range(0, 24) == 0);
            load_bin = WIDTH'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
